// File: rtl/hyperbus_pkg.sv
// -----------------------------------------------------------------------------
// hyperbus_pkg
// Shared types for the HyperBus transaction arbiter.
//   hyper_arb_state_t  : arbiter FSM states (IDLE, ISSUE, DATA).
//   hyper_trans_req_t  : one latched PHY transaction.
//   beats_to_transfer(): number of data beats a granted transaction moves.
// HYPER_BURST_W / HYPER_NR_CS size the struct; the arbiter's BURST_WIDTH and
// NR_CS parameters default to them and must stay equal to them.
// -----------------------------------------------------------------------------
package hyperbus_pkg;

  localparam int unsigned HYPER_BURST_W = 12;
  localparam int unsigned HYPER_NR_CS   = 2;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DATA  = 2'd2
  } hyper_arb_state_t;

  typedef struct packed {
    logic [31:0]              address;
    logic [HYPER_NR_CS-1:0]   cs;
    logic                     write;
    logic [HYPER_BURST_W-1:0] burst;
    logic                     address_space;
  } hyper_trans_req_t;

  // Register-space accesses always move exactly one word, whatever the burst.
  function automatic logic [HYPER_BURST_W-1:0] beats_to_transfer(input hyper_trans_req_t req);
    return req.address_space ? HYPER_BURST_W'(1) : req.burst;
  endfunction

endpackage

// File: rtl/hyperbus_rr_select.sv
// -----------------------------------------------------------------------------
// hyperbus_rr_select
// Combinational rotating-priority picker: returns the first set bit of valid_i
// at or after ptr_i, wrapping around. With ptr_i tied to 0 it is a plain
// lowest-index-wins priority encoder.
// Ports:
//   valid_i  [NR_MASTERS]  pending requests
//   ptr_i    [IDX_W]       index with highest priority this cycle (< NR_MASTERS)
//   onehot_o [NR_MASTERS]  one-hot winner, 0 when nothing is pending
//   idx_o    [IDX_W]       binary winner index, 0 when nothing is pending
//   found_o                any request pending
// -----------------------------------------------------------------------------
module hyperbus_rr_select #(
  parameter  int unsigned NR_MASTERS = 2,
  localparam int unsigned IDX_W      = $clog2(NR_MASTERS)
) (
  input  logic [NR_MASTERS-1:0] valid_i,
  input  logic [IDX_W-1:0]      ptr_i,
  output logic [NR_MASTERS-1:0] onehot_o,
  output logic [IDX_W-1:0]      idx_o,
  output logic                  found_o
);

  always_comb begin
    // NOTE: combinational blocks use blocking assignments and give every
    // output a default first, so no path leaves a value held (no latch).
    logic [IDX_W:0]      cand;
    logic [NR_MASTERS-1:0] onehot;
    logic [IDX_W-1:0]    idx;
    logic                found;
    cand   = '0;
    onehot = '0;
    idx    = '0;
    found  = 1'b0;
    for (int unsigned i = 0; i < NR_MASTERS; i++) begin
      // One extra bit so ptr + i cannot overflow before the modulo wrap.
      cand = {1'b0, ptr_i} + (IDX_W+1)'(i);
      if (cand >= (IDX_W+1)'(NR_MASTERS)) begin
        cand = cand - (IDX_W+1)'(NR_MASTERS);
      end
      if (!found && valid_i[cand[IDX_W-1:0]]) begin
        found                  = 1'b1;
        idx                    = cand[IDX_W-1:0];
        onehot[cand[IDX_W-1:0]] = 1'b1;
      end
    end
    onehot_o = onehot;
    idx_o    = idx;
    found_o  = found;
  end

endmodule

// File: rtl/hyperbus_trans_arbiter.sv
// -----------------------------------------------------------------------------
// hyperbus_trans_arbiter
// Shares one HyperBus PHY transaction / tx / rx port set between NR_MASTERS
// requesters. A pending request is picked round-robin in IDLE, latched and
// offered to the PHY in ISSUE, and the tx/rx streams are then locked to the
// winner in DATA until the last beat. Data paths are pure muxes.
// Build option: define HYPERBUS_ARB_FIXED_PRIO_EN to drop the round-robin
// pointer; the lowest-index valid master then always wins.
// Ports (per-master buses are packed [NR_MASTERS-1:0][W-1:0]):
//   clk_i, rst_ni                       clock, async active-low reset
//   req_valid_i/req_ready_o             per-master transaction handshake
//   req_address_i/cs_i/write_i/burst_i/address_space_i  request fields
//   tx_valid_i/tx_ready_o/tx_data_i/tx_strb_i           per-master write data
//   rx_valid_o/rx_ready_i, rx_data_o                    per-master read data
//   trans_valid_o/trans_ready_i, trans_*_o              PHY transaction
//   tx_valid_o/tx_ready_i/tx_data_o/tx_strb_o           PHY write stream
//   rx_valid_i/rx_ready_o/rx_data_i                     PHY read stream
//   grant_o                             one-hot owner, 0 when idle
//   busy_o                              high outside IDLE
// -----------------------------------------------------------------------------
module hyperbus_trans_arbiter
  import hyperbus_pkg::*;
#(
  parameter  int unsigned NR_MASTERS  = 2,
  parameter  int unsigned BURST_WIDTH = HYPER_BURST_W,
  parameter  int unsigned NR_CS       = HYPER_NR_CS,
  localparam int unsigned IDX_W       = $clog2(NR_MASTERS)
) (
  input  logic                                   clk_i,
  input  logic                                   rst_ni,
  // requester side
  input  logic [NR_MASTERS-1:0]                  req_valid_i,
  output logic [NR_MASTERS-1:0]                  req_ready_o,
  input  logic [NR_MASTERS-1:0][31:0]            req_address_i,
  input  logic [NR_MASTERS-1:0][NR_CS-1:0]       req_cs_i,
  input  logic [NR_MASTERS-1:0]                  req_write_i,
  input  logic [NR_MASTERS-1:0]                  req_address_space_i,
  input  logic [NR_MASTERS-1:0][BURST_WIDTH-1:0] req_burst_i,
  input  logic [NR_MASTERS-1:0]                  tx_valid_i,
  output logic [NR_MASTERS-1:0]                  tx_ready_o,
  input  logic [NR_MASTERS-1:0][15:0]            tx_data_i,
  input  logic [NR_MASTERS-1:0][1:0]             tx_strb_i,
  output logic [NR_MASTERS-1:0]                  rx_valid_o,
  input  logic [NR_MASTERS-1:0]                  rx_ready_i,
  output logic [15:0]                            rx_data_o,
  // PHY side
  output logic                                   trans_valid_o,
  input  logic                                   trans_ready_i,
  output logic [31:0]                            trans_address_o,
  output logic [NR_CS-1:0]                       trans_cs_o,
  output logic                                   trans_write_o,
  output logic [BURST_WIDTH-1:0]                 trans_burst_o,
  output logic                                   trans_address_space_o,
  output logic                                   tx_valid_o,
  input  logic                                   tx_ready_i,
  output logic [15:0]                            tx_data_o,
  output logic [1:0]                             tx_strb_o,
  input  logic                                   rx_valid_i,
  output logic                                   rx_ready_o,
  input  logic [15:0]                            rx_data_i,
  // status
  output logic [NR_MASTERS-1:0]                  grant_o,
  output logic                                   busy_o
);

  hyper_arb_state_t         state_q, state_d;
  hyper_trans_req_t         trans_q, trans_d;
  logic [IDX_W-1:0]         gnt_idx_q, gnt_idx_d;
  logic [BURST_WIDTH-1:0]   beat_cnt_q, beat_cnt_d;

  logic [NR_MASTERS-1:0]    sel_onehot;
  logic [IDX_W-1:0]         sel_idx;
  logic                     sel_found;
  logic [IDX_W-1:0]         sel_ptr;

  logic                     in_data_wr;
  logic                     in_data_rd;
  logic                     tx_beat;
  logic                     rx_beat;

  hyperbus_rr_select #(
    .NR_MASTERS (NR_MASTERS)
  ) u_select (
    .valid_i  (req_valid_i),
    .ptr_i    (sel_ptr),
    .onehot_o (sel_onehot),
    .idx_o    (sel_idx),
    .found_o  (sel_found)
  );

`ifdef HYPERBUS_ARB_FIXED_PRIO_EN
  // Master 0 always has top priority.
  assign sel_ptr = '0;
`else
  logic [IDX_W-1:0] rr_ptr_q, rr_ptr_d;

  // After a grant the master just served drops to lowest priority.
  always_comb begin
    rr_ptr_d = rr_ptr_q;
    if (state_q == IDLE && sel_found) begin
      rr_ptr_d = (sel_idx == IDX_W'(NR_MASTERS - 1)) ? '0 : sel_idx + IDX_W'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rr_ptr_q <= '0;
    end else begin
      rr_ptr_q <= rr_ptr_d;
    end
  end

  assign sel_ptr = rr_ptr_q;
`endif

  // Stream handshakes only count while the owner's direction is active, so
  // PHY data is never consumed on behalf of nobody.
  assign in_data_wr = (state_q == DATA) &&  trans_q.write;
  assign in_data_rd = (state_q == DATA) && !trans_q.write;
  assign tx_beat    = in_data_wr && tx_valid_i[gnt_idx_q] && tx_ready_i;
  assign rx_beat    = in_data_rd && rx_valid_i && rx_ready_i[gnt_idx_q];

  always_comb begin
    state_d    = state_q;
    trans_d    = trans_q;
    gnt_idx_d  = gnt_idx_q;
    beat_cnt_d = beat_cnt_q;
    unique case (state_q)
      IDLE: begin
        if (sel_found) begin
          trans_d = '{
            address:       req_address_i[sel_idx],
            cs:            req_cs_i[sel_idx],
            write:         req_write_i[sel_idx],
            burst:         req_burst_i[sel_idx],
            address_space: req_address_space_i[sel_idx]
          };
          gnt_idx_d = sel_idx;
          state_d   = ISSUE;
        end
      end
      ISSUE: begin
        if (trans_ready_i) begin
          beat_cnt_d = beats_to_transfer(trans_q);
          // A zero-length memory burst has no data phase at all.
          state_d    = (beats_to_transfer(trans_q) == '0) ? IDLE : DATA;
        end
      end
      DATA: begin
        if ((tx_beat || rx_beat) && beat_cnt_q != '0) begin
          beat_cnt_d = beat_cnt_q - BURST_WIDTH'(1);
          if (beat_cnt_q == BURST_WIDTH'(1)) begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    // NOTE: the latched transaction is reset too, because trans_*_o drive
    // straight off it and must read 0 out of reset.
    if (!rst_ni) begin
      state_q    <= IDLE;
      trans_q    <= '0;
      gnt_idx_q  <= '0;
      beat_cnt_q <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every flop
      // samples the pre-edge values regardless of statement order.
      state_q    <= state_d;
      trans_q    <= trans_d;
      gnt_idx_q  <= gnt_idx_d;
      beat_cnt_q <= beat_cnt_d;
    end
  end

  always_comb begin
    req_ready_o = '0;
    grant_o     = '0;
    tx_valid_o  = 1'b0;
    tx_data_o   = '0;
    tx_strb_o   = '0;
    tx_ready_o  = '0;
    rx_valid_o  = '0;
    rx_ready_o  = 1'b0;
    if (state_q == IDLE && sel_found) begin
      req_ready_o = sel_onehot;
    end
    if (state_q != IDLE) begin
      grant_o[gnt_idx_q] = 1'b1;
    end
    if (in_data_wr) begin
      tx_valid_o            = tx_valid_i[gnt_idx_q];
      tx_data_o             = tx_data_i[gnt_idx_q];
      tx_strb_o             = tx_strb_i[gnt_idx_q];
      tx_ready_o[gnt_idx_q] = tx_ready_i;
    end
    if (in_data_rd) begin
      rx_valid_o[gnt_idx_q] = rx_valid_i;
      rx_ready_o            = rx_ready_i[gnt_idx_q];
    end
  end

  assign trans_valid_o         = (state_q == ISSUE);
  assign trans_address_o       = trans_q.address;
  assign trans_cs_o            = trans_q.cs;
  assign trans_write_o         = trans_q.write;
  assign trans_burst_o         = trans_q.burst;
  assign trans_address_space_o = trans_q.address_space;
  assign rx_data_o             = rx_data_i;
  assign busy_o                = (state_q != IDLE);

endmodule

// File: tb/tb_hyperbus_trans_arbiter.sv
// -----------------------------------------------------------------------------
// tb_hyperbus_trans_arbiter
// Drives both requester ports and the PHY side of hyperbus_trans_arbiter with
// directed and randomized transactions. Expected grant order comes from a
// behavioural round-robin (or fixed-priority) model; expected beat counts and
// stream routing are derived per transaction from the request fields.
// -----------------------------------------------------------------------------
module tb_hyperbus_trans_arbiter;

  localparam int N   = 2;
  localparam int BW  = 12;
  localparam int NCS = 2;

  logic clk_i  = 1'b0;
  logic rst_ni = 1'b0;
  always #5 clk_i = ~clk_i;

  logic [N-1:0]          req_valid_i;
  logic [N-1:0]          req_ready_o;
  logic [N-1:0][31:0]    req_address_i;
  logic [N-1:0][NCS-1:0] req_cs_i;
  logic [N-1:0]          req_write_i;
  logic [N-1:0]          req_address_space_i;
  logic [N-1:0][BW-1:0]  req_burst_i;
  logic [N-1:0]          tx_valid_i;
  logic [N-1:0]          tx_ready_o;
  logic [N-1:0][15:0]    tx_data_i;
  logic [N-1:0][1:0]     tx_strb_i;
  logic [N-1:0]          rx_valid_o;
  logic [N-1:0]          rx_ready_i;
  logic [15:0]           rx_data_o;
  logic                  trans_valid_o;
  logic                  trans_ready_i;
  logic [31:0]           trans_address_o;
  logic [NCS-1:0]        trans_cs_o;
  logic                  trans_write_o;
  logic [BW-1:0]         trans_burst_o;
  logic                  trans_address_space_o;
  logic                  tx_valid_o;
  logic                  tx_ready_i;
  logic [15:0]           tx_data_o;
  logic [1:0]            tx_strb_o;
  logic                  rx_valid_i;
  logic                  rx_ready_o;
  logic [15:0]           rx_data_i;
  logic [N-1:0]          grant_o;
  logic                  busy_o;

  hyperbus_trans_arbiter #(
    .NR_MASTERS  (N),
    .BURST_WIDTH (BW),
    .NR_CS       (NCS)
  ) dut (
    .clk_i                 (clk_i),
    .rst_ni                (rst_ni),
    .req_valid_i           (req_valid_i),
    .req_ready_o           (req_ready_o),
    .req_address_i         (req_address_i),
    .req_cs_i              (req_cs_i),
    .req_write_i           (req_write_i),
    .req_address_space_i   (req_address_space_i),
    .req_burst_i           (req_burst_i),
    .tx_valid_i            (tx_valid_i),
    .tx_ready_o            (tx_ready_o),
    .tx_data_i             (tx_data_i),
    .tx_strb_i             (tx_strb_i),
    .rx_valid_o            (rx_valid_o),
    .rx_ready_i            (rx_ready_i),
    .rx_data_o             (rx_data_o),
    .trans_valid_o         (trans_valid_o),
    .trans_ready_i         (trans_ready_i),
    .trans_address_o       (trans_address_o),
    .trans_cs_o            (trans_cs_o),
    .trans_write_o         (trans_write_o),
    .trans_burst_o         (trans_burst_o),
    .trans_address_space_o (trans_address_space_o),
    .tx_valid_o            (tx_valid_o),
    .tx_ready_i            (tx_ready_i),
    .tx_data_o             (tx_data_o),
    .tx_strb_o             (tx_strb_o),
    .rx_valid_i            (rx_valid_i),
    .rx_ready_o            (rx_ready_o),
    .rx_data_i             (rx_data_i),
    .grant_o               (grant_o),
    .busy_o                (busy_o)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // ---------------- reference model: who wins next -------------------------
  int model_ptr = 0;

  function automatic int model_pick(input logic [N-1:0] mask);
    int c;
    for (int k = 0; k < N; k++) begin
      c = (model_ptr + k) % N;
      if (mask[c]) return c;
    end
    return -1;
  endfunction

  function automatic void model_granted(input int w);
`ifdef HYPERBUS_ARB_FIXED_PRIO_EN
    model_ptr = 0;
`else
    model_ptr = (w + 1) % N;
`endif
  endfunction

  // ---------------- pending request fields per master -----------------------
  logic [31:0]    p_addr  [N];
  logic [NCS-1:0] p_cs    [N];
  logic           p_write [N];
  logic           p_asp   [N];
  logic [BW-1:0]  p_burst [N];

  task automatic load_req(input int m, input bit w, input bit asp, input int burst);
    p_addr[m]  = $urandom;
    p_cs[m]    = NCS'($urandom_range(1, (1 << NCS) - 1));
    p_write[m] = w;
    p_asp[m]   = asp;
    p_burst[m] = BW'(burst);
    req_address_i[m]       = p_addr[m];
    req_cs_i[m]            = p_cs[m];
    req_write_i[m]         = p_write[m];
    req_address_space_i[m] = p_asp[m];
    req_burst_i[m]         = p_burst[m];
    req_valid_i[m]         = 1'b1;
  endtask

  task automatic rand_req(input int m);
    load_req(m, 1'($urandom % 2), ($urandom % 8) == 0, int'($urandom % 7));
  endtask

  task automatic clear_stim();
    tx_valid_i    = '0;
    tx_ready_i    = 1'b0;
    rx_valid_i    = 1'b0;
    rx_ready_i    = '0;
    trans_ready_i = 1'b0;
  endtask

  task automatic pulse_reset();
    @(negedge clk_i);
    rst_ni      = 1'b0;
    req_valid_i = '0;
    clear_stim();
    model_ptr   = 0;
    @(negedge clk_i);
    rst_ni      = 1'b1;
  endtask

  // Serves the transaction the model says wins next. Call just after a
  // negedge. mode 1 = owner always valid, tx_ready_i toggling 1,0,1,0,...
  // abort_after > 0 pulses reset once that many beats have moved.
  task automatic run_txn(input bit rearm, input int mode, input int abort_after);
    int            m;
    int            e_beats;
    int            done;
    int            cyc;
    int            stall;
    bit            hs;
    bit            force_hs;
    logic [N-1:0]  exp_oh;
    logic [N-1:0]  exp_vec;
    logic [31:0]   e_addr;
    logic [NCS-1:0] e_cs;
    logic          e_write;
    logic          e_asp;
    logic [BW-1:0] e_burst;

    m = model_pick(req_valid_i);
    if (m < 0) return;
    exp_oh    = '0;
    exp_oh[m] = 1'b1;

    for (int g = 0; g < 20; g++) begin
      if (req_ready_o != '0) break;
      @(negedge clk_i);
      #1;
    end
    check("req_ready", req_ready_o, exp_oh);

    e_addr  = p_addr[m];
    e_cs    = p_cs[m];
    e_write = p_write[m];
    e_asp   = p_asp[m];
    e_burst = p_burst[m];
    e_beats = e_asp ? 1 : int'(e_burst);
    model_granted(m);

    // ISSUE: PHY accepts after a few random stalls at most
    for (int c = 0; c < 12; c++) begin
      @(negedge clk_i);
      if (c == 0) begin
        if (rearm) rand_req(m);
        else       req_valid_i[m] = 1'b0;
      end
      trans_ready_i = (c >= 4) || ($urandom % 2 == 1);
      tx_valid_i    = '1;
      tx_ready_i    = 1'b1;
      rx_valid_i    = 1'b1;
      rx_ready_i    = '1;
      #1;
      check("trans_valid", trans_valid_o, 1);
      check("trans_addr", trans_address_o, e_addr);
      check("trans_cs", trans_cs_o, e_cs);
      check("trans_write", trans_write_o, e_write);
      check("trans_burst", trans_burst_o, e_burst);
      check("trans_asp", trans_address_space_o, e_asp);
      check("issue_grant", grant_o, exp_oh);
      check("issue_busy", busy_o, 1);
      check("issue_tx_valid", tx_valid_o, 0);
      check("issue_rx_ready", rx_ready_o, 0);
      check("issue_req_ready", req_ready_o, 0);
      if (trans_ready_i) break;
    end

    // DATA
    done  = 0;
    cyc   = 0;
    stall = 0;
    while (done < e_beats && cyc < 200) begin
      @(negedge clk_i);
      cyc++;
      if (abort_after > 0 && done == abort_after) begin
        rst_ni     = 1'b0;
        rx_valid_i = 1'b1;
        rx_ready_i = '1;
        tx_valid_i = '1;
        tx_ready_i = 1'b1;
        #1;
        check("rst_busy", busy_o, 0);
        check("rst_grant", grant_o, 0);
        check("rst_rx_valid", rx_valid_o, 0);
        check("rst_rx_ready", rx_ready_o, 0);
        check("rst_tx_valid", tx_valid_o, 0);
        check("rst_tx_ready", tx_ready_o, 0);
        check("rst_trans_valid", trans_valid_o, 0);
        check("rst_trans_addr", trans_address_o, 0);
        check("rst_trans_burst", trans_burst_o, 0);
        check("rst_req_ready", req_ready_o, 0);
        model_ptr = 0;
        clear_stim();
        @(negedge clk_i);
        rst_ni = 1'b1;
        return;
      end
      force_hs = (stall >= 3);
      for (int k = 0; k < N; k++) begin
        tx_valid_i[k] = 1'($urandom % 2);
        tx_data_i[k]  = 16'($urandom);
        tx_strb_i[k]  = 2'($urandom);
        rx_ready_i[k] = 1'($urandom % 2);
      end
      rx_data_i  = 16'($urandom);
      rx_valid_i = force_hs || ($urandom % 4 != 0);
      tx_ready_i = force_hs || ($urandom % 4 != 0);
      tx_valid_i[m] = force_hs || ($urandom % 4 != 0);
      rx_ready_i[m] = force_hs || ($urandom % 4 != 0);
      if (mode == 1) begin
        tx_valid_i[m] = 1'b1;
        tx_ready_i    = (cyc % 2 == 1);
      end
      #1;
      exp_vec = '0;
      if (e_write) begin
        exp_vec[m] = tx_ready_i;
        check("tx_valid", tx_valid_o, tx_valid_i[m]);
        check("tx_ready_route", tx_ready_o, exp_vec);
        if (tx_valid_i[m]) begin
          check("tx_data", tx_data_o, tx_data_i[m]);
          check("tx_strb", tx_strb_o, tx_strb_i[m]);
        end
        check("wr_rx_valid", rx_valid_o, 0);
        check("wr_rx_ready", rx_ready_o, 0);
        hs = tx_valid_i[m] && tx_ready_i;
      end else begin
        exp_vec[m] = rx_valid_i;
        check("rx_valid_route", rx_valid_o, exp_vec);
        check("rx_ready", rx_ready_o, rx_ready_i[m]);
        check("rx_data", rx_data_o, rx_data_i);
        check("rd_tx_valid", tx_valid_o, 0);
        check("rd_tx_ready", tx_ready_o, 0);
        hs = rx_valid_i && rx_ready_i[m];
      end
      check("data_grant", grant_o, exp_oh);
      check("data_busy", busy_o, 1);
      check("data_trans_valid", trans_valid_o, 0);
      if (hs) begin
        done++;
        stall = 0;
      end else begin
        stall++;
      end
    end

    // One cycle after the last beat (or the trans handshake for 0 beats).
    @(negedge clk_i);
    tx_valid_i = '1;
    tx_ready_i = 1'b1;
    rx_valid_i = 1'b1;
    rx_ready_i = '1;
    #1;
    check("end_busy", busy_o, 0);
    check("end_grant", grant_o, 0);
    check("end_tx_valid", tx_valid_o, 0);
    check("end_rx_ready", rx_ready_o, 0);
    check("end_rx_valid", rx_valid_o, 0);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

  initial begin
    int  budget;
    int  guard;
    bit  r;
    logic [N-1:0] mask;

    req_valid_i         = '0;
    req_address_i       = '0;
    req_cs_i            = '0;
    req_write_i         = '0;
    req_address_space_i = '0;
    req_burst_i         = '0;
    tx_data_i           = '0;
    tx_strb_i           = '0;
    clear_stim();
    rx_data_i = 16'hA55A;

    // Reset state: drive live data inputs to prove the outputs are gated.
    repeat (3) @(negedge clk_i);
    tx_valid_i = '1;
    tx_ready_i = 1'b1;
    rx_valid_i = 1'b1;
    rx_ready_i = '1;
    tx_data_i  = {N{16'hBEEF}};
    #1;
    check("reset_req_ready", req_ready_o, 0);
    check("reset_trans_valid", trans_valid_o, 0);
    check("reset_trans_addr", trans_address_o, 0);
    check("reset_trans_burst", trans_burst_o, 0);
    check("reset_grant", grant_o, 0);
    check("reset_busy", busy_o, 0);
    check("reset_tx_valid", tx_valid_o, 0);
    check("reset_tx_data", tx_data_o, 0);
    check("reset_rx_valid", rx_valid_o, 0);
    check("reset_rx_ready", rx_ready_o, 0);
    check("reset_rx_data", rx_data_o, 16'hA55A);
    @(negedge clk_i);
    rst_ni = 1'b1;
    clear_stim();

    // Single read, master 1, burst 4.
    @(negedge clk_i);
    load_req(1, 1'b0, 1'b0, 4);
    #1;
    run_txn(1'b0, 0, 0);

    // Both masters pending straight after reset, kept pending for 4 grants.
    pulse_reset();
    load_req(0, 1'b0, 1'b0, int'($urandom % 3));
    load_req(1, 1'b1, 1'b0, int'($urandom % 3));
    #1;
    for (int t = 0; t < 4; t++) run_txn(t < 3, 0, 0);
    guard = 0;
    while (req_valid_i != '0 && guard < 8) begin
      run_txn(1'b0, 0, 0);
      guard++;
    end

    // Write burst 3 by master 1 with tx_ready_i toggling.
    load_req(1, 1'b1, 1'b0, 3);
    #1;
    run_txn(1'b0, 1, 0);

    // Register write with burst 8: one beat only.
    load_req(0, 1'b1, 1'b1, 8);
    #1;
    run_txn(1'b0, 0, 0);

    // Memory read and write with burst 0: no data phase.
    load_req(1, 1'b0, 1'b0, 0);
    #1;
    run_txn(1'b0, 0, 0);
    load_req(0, 1'b1, 1'b0, 0);
    #1;
    run_txn(1'b0, 0, 0);

    // Reset after beat 2 of a 5-beat read, then a normal grant.
    load_req(0, 1'b0, 1'b0, 5);
    #1;
    run_txn(1'b0, 0, 2);
    load_req(1, 1'b0, 1'b0, 2);
    #1;
    run_txn(1'b0, 0, 0);

    // Randomized traffic.
    for (int it = 0; it < 40; it++) begin
      mask = N'($urandom_range(1, (1 << N) - 1));
      for (int m = 0; m < N; m++) if (mask[m]) rand_req(m);
      #1;
      budget = 3;
      guard  = 0;
      while (req_valid_i != '0 && guard < 20) begin
        r = (budget > 0) && ($urandom % 3 == 0);
        if (r) budget--;
        run_txn(r, 0, 0);
        guard++;
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
